stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 136 +++++++++++++
 tb/tb_stream_mux_rr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Round-robin N:1 valid/ready stream mux with a registered output; STREAM_MUX_LOCK_EN holds the grant until in_last.
// Latency: 1 cycle from input handshake to out_valid; one beat per cycle while out_ready=1.
// Backpressure: out_valid && !out_ready freezes the output register and the pointer, and drops all in_ready.
module stream_mux_rr #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   input  logic [N-1:0]      in_last,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic [SELW-1:0]   out_sel,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef struct packed {
      logic [W-1:0]    data;
      logic [SELW-1:0] sel;
      logic            last;
   } beat_t;

   beat_t           out_q;
   beat_t           beat_d;
   logic [W-1:0]    ch_data [N];
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] ptr_nxt;
   logic [SELW-1:0] rr_g;
   logic            rr_any;
   logic [SELW-1:0] g;
   logic            any_valid;
   logic            load;
   logic            xfer;
   logic [SELW:0]   idx_w;
   logic [SELW-1:0] idx;

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign ch_data[i] = in_data[i*W +: W];
   end

   // First valid channel scanning upward from ptr, wrapping modulo N.
   always_comb begin
      rr_g   = '0;
      rr_any = 1'b0;
      idx_w  = '0;
      idx    = '0;
      for (int k = 0; k < N; k++) begin
         idx_w = {1'b0, ptr} + (SELW+1)'(k);
         if (idx_w >= (SELW+1)'(N)) begin
            idx_w = idx_w - (SELW+1)'(N);
         end
         idx = idx_w[SELW-1:0];
         if (!rr_any && in_valid[idx]) begin
            rr_any = 1'b1;
            rr_g   = idx;
         end
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   logic            lock_q;
   logic [SELW-1:0] lock_ch;

   // While a packet is open only its channel may win, even if it is idle.
   always_comb begin
      g         = rr_g;
      any_valid = rr_any;
      if (lock_q) begin
         g         = lock_ch;
         any_valid = in_valid[lock_ch];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q  <= 1'b0;
         lock_ch <= '0;
      end else if (xfer) begin
         lock_q  <= !in_last[g];
         lock_ch <= g;
      end
   end
`else
   assign g         = rr_g;
   assign any_valid = rr_any;
`endif

   assign load    = !out_valid || out_ready;
   assign xfer    = load && any_valid;
   assign ptr_nxt = (g == SELW'(N-1)) ? '0 : g + SELW'(1);

   always_comb begin
      in_ready = '0;
      if (rst_n && xfer) begin
         in_ready[g] = 1'b1;
      end
   end

   always_comb begin
      beat_d.data = ch_data[g];
      beat_d.sel  = g;
      beat_d.last = in_last[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q     <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         if (load) begin
            out_valid <= any_valid;
         end
         if (xfer) begin
            out_q <= beat_d;
`ifdef STREAM_MUX_LOCK_EN
            if (in_last[g]) begin
               ptr <= ptr_nxt;
            end
`else
            ptr <= ptr_nxt;
`endif
         end
      end
   end

   assign out_data = out_q.data;
   assign out_sel  = out_q.sel;
   assign out_last = out_q.last;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr at N=4, W=8: reset, single channel, rotation, backpressure, streaming, packet lock.
module tb_stream_mux_rr;
   localparam int N    = 4;
   localparam int W    = 8;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_ready;
   logic [W-1:0]    out_data;
   logic [SELW-1:0] out_sel;
   logic            out_last;
   logic            out_valid;
   logic            out_ready;

   int checks = 0;
   int errors = 0;

   stream_mux_rr #(.N(N), .W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setd(input int ch, input logic [7:0] d);
      in_data[ch*W +: W] = d;
   endtask

   initial begin
      int exp_sel [5];
      int lk_sel  [4];
      int cnt0;

      // Power-on reset, with every channel requesting.
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 4'b1111;
      in_last   = '0;
      out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data),  'h00);
      chk("rst_out_sel",   32'(out_sel),   0);
      chk("rst_out_last",  32'(out_last),  0);
      chk("rst_in_ready",  32'(in_ready),  'b0000);
      chk("rst_ptr",       32'(dut.ptr),   0);
      tick();
      tick();
      rst_n    = 1'b1;
      in_valid = '0;

      // Single channel 2.
      setd(2, 8'hA5);
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready), 'b0100);
      tick();
      in_valid  = '0;
      out_ready = 1'b0;
      #1;
      chk("single_out_valid", 32'(out_valid), 1);
      chk("single_out_data",  32'(out_data),  'hA5);
      chk("single_out_sel",   32'(out_sel),   2);
      chk("single_ptr",       32'(dut.ptr),   3);

      // Asynchronous reset mid-cycle while a beat is held.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_data",  32'(out_data),  'h00);
      chk("arst_out_sel",   32'(out_sel),   0);
      chk("arst_ptr",       32'(dut.ptr),   0);
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      chk("arst_in_ready", 32'(in_ready), 'b0000);
      tick();
      tick();
      rst_n = 1'b1;

      // Round-robin rotation with all channels valid.
      for (int i = 0; i < N; i++) setd(i, 8'(8'h10 + i));
      exp_sel = '{0, 1, 2, 3, 0};
      #1;
      chk("rr_first_ready", 32'(in_ready), 'b0001);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 1);
         chk($sformatf("rr_sel_%0d", k),   32'(out_sel),   exp_sel[k]);
         chk($sformatf("rr_data_%0d", k),  32'(out_data),  'h10 + exp_sel[k]);
      end
      tick();
      chk("bp_load_sel",  32'(out_sel),  1);
      chk("bp_load_data", 32'(out_data), 'h11);

      // Backpressure for three cycles holding ch1's beat.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 'b0000);
         tick();
         chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 1);
         chk($sformatf("bp_data_%0d", k),  32'(out_data),  'h11);
         chk($sformatf("bp_sel_%0d", k),   32'(out_sel),   1);
         chk($sformatf("bp_ptr_%0d", k),   32'(dut.ptr),   2);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 'b0100);
      tick();
      chk("bp_next_valid", 32'(out_valid), 1);
      chk("bp_next_sel",   32'(out_sel),   2);
      chk("bp_next_data",  32'(out_data),  'h12);

      // Back-to-back stream from ch1.
      in_valid = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         setd(1, 8'(8'h40 + k));
         tick();
         chk($sformatf("b2b_valid_%0d", k), 32'(out_valid), 1);
         chk($sformatf("b2b_sel_%0d", k),   32'(out_sel),   1);
         chk($sformatf("b2b_data_%0d", k),  32'(out_data),  'h40 + k);
      end
      in_valid = '0;
      tick();
      chk("drain_valid", 32'(out_valid), 0);
      chk("drain_hold",  32'(out_data),  'h45);

      // Packet: ch0 sends last=0,0,1 while ch1 stays valid with a one-beat packet.
`ifdef STREAM_MUX_LOCK_EN
      lk_sel = '{0, 0, 0, 1};
`else
      lk_sel = '{0, 1, 0, 1};
`endif
      cnt0 = 0;
      setd(1, 8'h61);
      in_last[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         setd(0, 8'(8'h50 + cnt0));
         in_last[0]  = (cnt0 == 2);
         in_valid[0] = (cnt0 < 3);
         in_valid[1] = 1'b1;
         tick();
         chk($sformatf("pkt_sel_%0d", k), 32'(out_sel), lk_sel[k]);
         if (lk_sel[k] == 0) begin
            chk($sformatf("pkt_data_%0d", k), 32'(out_data), 'h50 + cnt0);
            chk($sformatf("pkt_last_%0d", k), 32'(out_last), (cnt0 == 2) ? 1 : 0);
            cnt0++;
         end else begin
            chk($sformatf("pkt_data_%0d", k), 32'(out_data), 'h61);
            chk($sformatf("pkt_last_%0d", k), 32'(out_last), 1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
